// File: rtl/alu_mb_seq.sv
// Multi-byte operation sequencer: walks an N-byte little-endian operand in
// data memory one byte per pass, drives the external 8-bit ALU and chains
// the carry/shift bit between bytes so wide add/sub/shift/or/xor run on the
// existing narrow datapath.
module alu_mb_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic [2:0]        alu_cmd,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_sci,
  input  logic [7:0]        alu_rslt,
  input  logic              alu_sco
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LSL = 3'd2;
  localparam logic [2:0] OP_RSL = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [2:0] CMD_ADD = 3'b110;
  localparam logic [2:0] CMD_LSL = 3'b010;
  localparam logic [2:0] CMD_RSL = 3'b101;
  localparam logic [2:0] CMD_XOR = 3'b100;
  localparam logic [2:0] CMD_OR  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_op;
  logic [ADDR_W-1:0]  r_a_base;
  logic [ADDR_W-1:0]  r_b_base;
  logic [ADDR_W-1:0]  r_d_base;
  logic [LEN_W-1:0]   r_cnt;      // bytes still to process, including current
  logic [LEN_W-1:0]   r_idx;      // current byte index
  logic [7:0]         r_a;        // captured A byte (binary ops only)
  logic [7:0]         r_result;
  logic               r_sc;       // chained carry/shift bit
  logic               r_carry;

  logic               w_binary;   // op reads a B operand
  logic               w_chain;    // op updates sc from the ALU
  logic               w_last;
  logic [ADDR_W-1:0]  w_idx_ext;

  assign w_binary  = (r_op != OP_LSL) && (r_op != OP_RSL);
  assign w_chain   = (r_op <= OP_RSL);
  assign w_last    = (r_cnt == LEN_W'(1));
  assign w_idx_ext = ADDR_W'(r_idx);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: shifts skip the B read, len=0 goes straight to DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = (len == '0) ? S_DONE : S_RD_A;
      S_RD_A: w_state_next = w_binary ? S_RD_B : S_EXEC;
      S_RD_B: w_state_next = S_EXEC;
      S_EXEC: w_state_next = S_WR;
      S_WR:   w_state_next = w_last ? S_DONE : S_RD_A;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers: launch latch, operand capture, result/sc, indexing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_d_base <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_a      <= '0;
      r_result <= '0;
      r_sc     <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_a_base <= a_base;
            r_b_base <= b_base;
            r_d_base <= d_base;
            r_cnt    <= len;
            // RSL walks MSB first so the shift bit moves downward.
            r_idx    <= (op == OP_RSL) ? (len - LEN_W'(1)) : '0;
            r_sc     <= (op == OP_SUB);
            if (len == '0) r_carry <= (op == OP_SUB);
          end
        end
        S_RD_B: r_a <= mem_rd_data;
        S_EXEC: begin
          r_result <= alu_rslt;
          if (w_chain) r_sc <= alu_sco;
        end
        S_WR: begin
          r_cnt <= r_cnt - LEN_W'(1);
          r_idx <= (r_op == OP_RSL) ? (r_idx - LEN_W'(1)) : (r_idx + LEN_W'(1));
          if (w_last) r_carry <= r_sc;
        end
        default: ;
      endcase
    end
  end

  // Output decode: strobes, addresses and ALU drive are zero outside their state.
  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    carry_out   = r_carry;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    alu_cmd     = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sci     = 1'b0;
    case (r_state)
      S_RD_A: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = r_a_base + w_idx_ext;
      end
      S_RD_B: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = r_b_base + w_idx_ext;
      end
      S_EXEC: begin
        // Binary ops have B on the read bus now; shifts still have A there.
        alu_a = w_binary ? r_a : mem_rd_data;
        case (r_op)
          OP_ADD: begin
            alu_cmd = CMD_ADD;
            alu_b   = mem_rd_data;
            alu_sci = r_sc;
          end
          OP_SUB: begin
            alu_cmd = CMD_ADD;
            alu_b   = ~mem_rd_data;
            alu_sci = r_sc;
          end
          OP_LSL: begin
            alu_cmd = CMD_LSL;
            alu_sci = r_sc;
          end
          OP_RSL: begin
            alu_cmd = CMD_RSL;
            alu_sci = r_sc;
          end
          OP_XOR: begin
            alu_cmd = CMD_XOR;
            alu_b   = mem_rd_data;
          end
          default: begin
            alu_cmd = CMD_OR;
            alu_b   = mem_rd_data;
          end
        endcase
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = r_d_base + w_idx_ext;
        mem_wr_data = r_result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mb_seq.sv
// Bench for alu_mb_seq: behavioural memory and ALU around the sequencer,
// directed operations with hand-computed results, scoreboard checking.
module tb_alu_mb_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] len = '0;
  logic [7:0] a_base = '0;
  logic [7:0] b_base = '0;
  logic [7:0] d_base = '0;
  logic       busy, done, carry_out;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [7:0] mem_rd_data = '0;
  logic [2:0] alu_cmd;
  logic [7:0] alu_a, alu_b, alu_rslt;
  logic       alu_sci, alu_sco;

  alu_mb_seq #(.ADDR_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
    .a_base(a_base), .b_base(b_base), .d_base(d_base),
    .busy(busy), .done(done), .carry_out(carry_out),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sci(alu_sci),
    .alu_rslt(alu_rslt), .alu_sco(alu_sco)
  );

  always #5 clk = ~clk;

  // Data memory with registered read and a bench-side preload port.
  logic [7:0] mem [0:255];
  logic       pk_en = 1'b0;
  logic [7:0] pk_addr = '0;
  logic [7:0] pk_data = '0;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
    if (pk_en)     mem[pk_addr] = pk_data;
  end

  // 8-bit ALU model.
  logic [8:0] sum9;
  always_comb begin
    alu_rslt = '0;
    alu_sco  = 1'b0;
    sum9     = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_sci};
    case (alu_cmd)
      3'b110: begin alu_rslt = sum9[7:0]; alu_sco = sum9[8]; end
      3'b010: begin alu_rslt = {alu_a[6:0], alu_sci}; alu_sco = alu_a[7]; end
      3'b101: begin alu_rslt = {alu_sci, alu_a[7:1]}; alu_sco = alu_a[0]; end
      3'b100: alu_rslt = alu_a ^ alu_b;
      3'b011: alu_rslt = alu_a | alu_b;
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic c; int lat; } done_t;
  logic [7:0] exp_rd[$];
  wr_t        exp_wr[$];
  done_t      exp_done[$];

  logic launch_flag = 1'b0;
  int   lat = 0;

  // Cycles since the launching edge: 1 in the cycle right after it.
  always @(posedge clk) lat <= launch_flag ? 1 : lat + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a strobe or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en || mem_wr_en)
        chk("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=0x%0h required=none", mem_rd_addr);
        end else begin
          chk("rd_addr", {24'b0, mem_rd_addr}, {24'b0, exp_rd.pop_front()});
        end
      end
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=0x%0h:0x%0h required=none", mem_wr_addr, mem_wr_data);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr_data", {16'b0, mem_wr_addr, mem_wr_data}, {16'b0, w.addr, w.data});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          done_t dn;
          dn = exp_done.pop_front();
          chk("carry_out", {31'b0, carry_out}, {31'b0, dn.c});
          chk("done_latency", lat, dn.lat);
        end
      end
    end
  end

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = addr; pk_data = data;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic ew(input logic [7:0] addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    exp_wr.push_back(w);
  endtask

  // Queue the read order and done expectation, then pulse start.
  task automatic issue(input logic [2:0] o, input logic [3:0] l, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] d, input logic c, input int lt);
    done_t dn;
    logic [7:0] idx, ad;
    for (int k = 0; k < int'(l); k++) begin
      idx = (o == 3'd3) ? 8'(int'(l) - 1 - k) : 8'(k);
      ad = a + idx;
      exp_rd.push_back(ad);
      if (o != 3'd2 && o != 3'd3) begin
        ad = b + idx;
        exp_rd.push_back(ad);
      end
    end
    dn.c = c; dn.lat = lt;
    exp_done.push_back(dn);
    @(negedge clk);
    op = o; len = l; a_base = a; b_base = b; d_base = d;
    start = 1'b1; launch_flag = 1'b1;
    @(negedge clk);
    start = 1'b0; launch_flag = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    #1;
    chk("queues_drained", exp_rd.size() + exp_wr.size() + exp_done.size(), 32'd0);
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    @(negedge clk);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {30'b0, busy, done}, 32'd0);
    chk("reset_carry", {31'b0, carry_out}, 32'd0);
    chk("reset_mem", {6'b0, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}, 32'd0);
    chk("reset_alu", {13'b0, alu_cmd, alu_a, alu_b, alu_sci}, 32'd0);
    rst_n = 1'b1;

    // ADD 2 bytes: 0x01FF + 0x0001 = 0x0200
    poke(8'h00, 8'hFF); poke(8'h01, 8'h01); poke(8'h08, 8'h01); poke(8'h09, 8'h00);
    ew(8'h20, 8'h00); ew(8'h21, 8'h02);
    issue(3'd0, 4'd2, 8'h00, 8'h08, 8'h20, 1'b0, 9);
    wait_done();

    // SUB 0x0100 - 0x0001 = 0x00FF, no borrow
    poke(8'h30, 8'h00); poke(8'h31, 8'h01); poke(8'h38, 8'h01); poke(8'h39, 8'h00);
    ew(8'h40, 8'hFF); ew(8'h41, 8'h00);
    issue(3'd1, 4'd2, 8'h30, 8'h38, 8'h40, 1'b1, 9);
    wait_done();

    // SUB 0x0000 - 0x0001 = 0xFFFF, borrow
    poke(8'h31, 8'h00);
    ew(8'h40, 8'hFF); ew(8'h41, 8'hFF);
    issue(3'd1, 4'd2, 8'h30, 8'h38, 8'h40, 1'b0, 9);
    wait_done();

    // LSL 3 bytes of 0x80
    poke(8'h50, 8'h80); poke(8'h51, 8'h80); poke(8'h52, 8'h80);
    ew(8'h60, 8'h00); ew(8'h61, 8'h01); ew(8'h62, 8'h01);
    issue(3'd2, 4'd3, 8'h50, 8'h00, 8'h60, 1'b1, 10);
    wait_done();

    // RSL same data, MSB byte written first
    ew(8'h72, 8'h40); ew(8'h71, 8'h40); ew(8'h70, 8'h40);
    issue(3'd3, 4'd3, 8'h50, 8'h00, 8'h70, 1'b0, 10);
    wait_done();

    // XOR in place
    poke(8'h10, 8'hF0); poke(8'h18, 8'h3C);
    ew(8'h10, 8'hCC);
    issue(3'd5, 4'd1, 8'h10, 8'h18, 8'h10, 1'b0, 5);
    wait_done();
    chk("xor_in_place_mem", {24'b0, mem[8'h10]}, 32'hCC);

    // OR with a start pulse while busy that must be ignored
    poke(8'h80, 8'h0F); poke(8'h81, 8'hF0); poke(8'h88, 8'h30); poke(8'h89, 8'h03);
    ew(8'h90, 8'h3F); ew(8'h91, 8'hF3);
    issue(3'd4, 4'd2, 8'h80, 8'h88, 8'h90, 1'b0, 9);
    repeat (2) @(negedge clk);
    op = 3'd0; len = 4'd1; a_base = 8'h00; b_base = 8'h08; d_base = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Address wrap: A at 0xFF,0x00
    poke(8'hFF, 8'h80); poke(8'h00, 8'h01); poke(8'hC0, 8'h80); poke(8'hC1, 8'h00);
    ew(8'hD0, 8'h00); ew(8'hD1, 8'h02);
    issue(3'd0, 4'd2, 8'hFF, 8'hC0, 8'hD0, 1'b0, 9);
    wait_done();

    // Reserved op code 7 acts as OR
    poke(8'hA0, 8'h51); poke(8'hA8, 8'h0A);
    ew(8'hB0, 8'h5B);
    issue(3'd7, 4'd1, 8'hA0, 8'hA8, 8'hB0, 1'b0, 5);
    wait_done();

    // len=0 SUB: done next cycle, carry = initial sc, no traffic
    issue(3'd1, 4'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1);
    wait_done();

    // Reset during EXEC of byte 1
    poke(8'hE0, 8'hFF); poke(8'hE1, 8'h01); poke(8'hE8, 8'h01); poke(8'hE9, 8'h00);
    poke(8'hF1, 8'h5A);
    ew(8'hF0, 8'h00);
    issue(3'd0, 4'd2, 8'hE0, 8'hE8, 8'hF0, 1'b0, 0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {30'b0, busy, done}, 32'd0);
    chk("abort_carry", {31'b0, carry_out}, 32'd0);
    chk("abort_mem", {6'b0, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}, 32'd0);
    chk("abort_alu", {13'b0, alu_cmd, alu_a, alu_b, alu_sci}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_traffic_done", exp_rd.size() + exp_wr.size(), 32'd0);
    chk("abort_busy_idle", {31'b0, busy}, 32'd0);
    chk("abort_byte0_kept", {24'b0, mem[8'hF0]}, 32'h00);
    chk("abort_byte1_untouched", {24'b0, mem[8'hF1]}, 32'h5A);
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();

    // Clean run after reset release
    ew(8'hF4, 8'hFE);
    issue(3'd2, 4'd1, 8'hE0, 8'h00, 8'hF4, 1'b1, 4);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
